// File: rtl/e_m_pipe_reg.sv
// E->M pipeline register: captures ALU results with control fields and folds ALU overflow
// (and, when EM_ALIGN_CHECK_EN is defined, access misalignment) into the exception code.
module e_m_pipe_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        En,
    input  logic        Flush,
    input  logic        Req,
    input  logic        E_Valid,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_Instr,
    input  logic [31:0] E_AO,
    input  logic        E_OverFlow,
    input  logic        E_OvCheck,
    input  logic [31:0] E_RT,
    input  logic [4:0]  E_A3,
    input  logic [4:0]  E_ExcCode,
    input  logic        E_BD,
    input  logic        E_MemRead,
    input  logic        E_MemWrite,
    input  logic [1:0]  E_MemWidth,
    output logic        M_Valid,
    output logic [31:0] M_PC,
    output logic [31:0] M_Instr,
    output logic [31:0] M_AO,
    output logic [31:0] M_RT,
    output logic [4:0]  M_A3,
    output logic [4:0]  M_ExcCode,
    output logic        M_BD,
    output logic        M_MemRead,
    output logic        M_MemWrite,
    output logic [1:0]  M_MemWidth
);

    localparam logic [4:0] ExcAdel = 5'd4;
    localparam logic [4:0] ExcAdes = 5'd5;
    localparam logic [4:0] ExcOv   = 5'd12;

    logic [4:0] ovf_exc;
    logic [4:0] align_exc;
    logic [4:0] new_exc;
    logic       suppress;

    logic        valid_q,     valid_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] instr_q,     instr_d;
    logic [31:0] ao_q,        ao_d;
    logic [31:0] rt_q,        rt_d;
    logic [4:0]  a3_q,        a3_d;
    logic [4:0]  exc_q,       exc_d;
    logic        bd_q,        bd_d;
    logic        mem_read_q,  mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [1:0]  mem_width_q, mem_width_d;

    // Overflow during address calculation is reported as an address error.
    always_comb begin
        if (E_MemRead) begin
            ovf_exc = ExcAdel;
        end else if (E_MemWrite) begin
            ovf_exc = ExcAdes;
        end else begin
            ovf_exc = ExcOv;
        end
    end

`ifdef EM_ALIGN_CHECK_EN
    localparam logic [1:0] WidthWord = 2'b00;
    localparam logic [1:0] WidthHalf = 2'b01;

    logic misaligned;

    always_comb begin
        case (E_MemWidth)
            WidthWord: misaligned = |E_AO[1:0];
            WidthHalf: misaligned = E_AO[0];
            default:   misaligned = 1'b0;
        endcase
        align_exc = 5'd0;
        if (misaligned && E_MemRead) begin
            align_exc = ExcAdel;
        end else if (misaligned && E_MemWrite) begin
            align_exc = ExcAdes;
        end
    end
`else
    assign align_exc = 5'd0;
`endif

    always_comb begin
        if (!E_Valid) begin
            new_exc = 5'd0;
        end else if (E_ExcCode != 5'd0) begin
            new_exc = E_ExcCode;
        end else if (E_OvCheck && E_OverFlow) begin
            new_exc = ovf_exc;
        end else begin
            new_exc = align_exc;
        end
    end

    assign suppress = (new_exc != 5'd0);

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        ao_d        = ao_q;
        rt_d        = rt_q;
        a3_d        = a3_q;
        exc_d       = exc_q;
        bd_d        = bd_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_width_d = mem_width_q;
        if (Req || Flush) begin
            valid_d     = 1'b0;
            instr_d     = 32'd0;
            ao_d        = 32'd0;
            rt_d        = 32'd0;
            a3_d        = 5'd0;
            exc_d       = 5'd0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            mem_width_d = 2'b00;
            // A flushed slot keeps E's PC/BD so EPC is right if M later excepts.
            pc_d        = Req ? EXC_PC : E_PC;
            bd_d        = Req ? 1'b0 : E_BD;
        end else if (En) begin
            valid_d     = E_Valid;
            pc_d        = E_PC;
            instr_d     = E_Instr;
            ao_d        = E_AO;
            rt_d        = E_RT;
            a3_d        = suppress ? 5'd0 : E_A3;
            exc_d       = new_exc;
            bd_d        = E_BD;
            mem_read_d  = suppress ? 1'b0 : E_MemRead;
            mem_write_d = suppress ? 1'b0 : E_MemWrite;
            mem_width_d = E_MemWidth;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= RESET_PC;
            instr_q     <= 32'd0;
            ao_q        <= 32'd0;
            rt_q        <= 32'd0;
            a3_q        <= 5'd0;
            exc_q       <= 5'd0;
            bd_q        <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_width_q <= 2'b00;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            ao_q        <= ao_d;
            rt_q        <= rt_d;
            a3_q        <= a3_d;
            exc_q       <= exc_d;
            bd_q        <= bd_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_width_q <= mem_width_d;
        end
    end

    assign M_Valid    = valid_q;
    assign M_PC       = pc_q;
    assign M_Instr    = instr_q;
    assign M_AO       = ao_q;
    assign M_RT       = rt_q;
    assign M_A3       = a3_q;
    assign M_ExcCode  = exc_q;
    assign M_BD       = bd_q;
    assign M_MemRead  = mem_read_q;
    assign M_MemWrite = mem_write_q;
    assign M_MemWidth = mem_width_q;

endmodule

// File: tb/tb_e_m_pipe_reg.sv
// Scoreboard bench for e_m_pipe_reg: stimulus pushes hand-computed expected M outputs,
// a monitor pops and compares one cycle later.
module tb_e_m_pipe_reg;

    typedef struct packed {
        logic        en, flush, req, valid;
        logic [31:0] pc, instr, ao;
        logic        ovf, ovchk;
        logic [31:0] rt;
        logic [4:0]  a3, exc;
        logic        bd, mr, mw;
        logic [1:0]  width;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, instr, ao, rt;
        logic [4:0]  a3, exc;
        logic        bd, mr, mw;
        logic [1:0]  width;
    } out_t;

    logic clk = 1'b0;
    logic reset;
    in_t  vin;
    out_t act;

    logic        M_Valid, M_BD, M_MemRead, M_MemWrite;
    logic [31:0] M_PC, M_Instr, M_AO, M_RT;
    logic [4:0]  M_A3, M_ExcCode;
    logic [1:0]  M_MemWidth;

    out_t exp_q[$];
    int   id_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    e_m_pipe_reg dut (
        .clk        (clk),
        .reset      (reset),
        .En         (vin.en),
        .Flush      (vin.flush),
        .Req        (vin.req),
        .E_Valid    (vin.valid),
        .E_PC       (vin.pc),
        .E_Instr    (vin.instr),
        .E_AO       (vin.ao),
        .E_OverFlow (vin.ovf),
        .E_OvCheck  (vin.ovchk),
        .E_RT       (vin.rt),
        .E_A3       (vin.a3),
        .E_ExcCode  (vin.exc),
        .E_BD       (vin.bd),
        .E_MemRead  (vin.mr),
        .E_MemWrite (vin.mw),
        .E_MemWidth (vin.width),
        .M_Valid    (M_Valid),
        .M_PC       (M_PC),
        .M_Instr    (M_Instr),
        .M_AO       (M_AO),
        .M_RT       (M_RT),
        .M_A3       (M_A3),
        .M_ExcCode  (M_ExcCode),
        .M_BD       (M_BD),
        .M_MemRead  (M_MemRead),
        .M_MemWrite (M_MemWrite),
        .M_MemWidth (M_MemWidth)
    );

    assign act = '{valid: M_Valid, pc: M_PC, instr: M_Instr, ao: M_AO, rt: M_RT, a3: M_A3,
                   exc: M_ExcCode, bd: M_BD, mr: M_MemRead, mw: M_MemWrite, width: M_MemWidth};

    // Straight field copy of E into M; each vector then overrides what it expects to differ.
    function automatic out_t pass(input in_t v);
        out_t e;
        e = '{valid: v.valid, pc: v.pc, instr: v.instr, ao: v.ao, rt: v.rt, a3: v.a3,
              exc: 5'd0, bd: v.bd, mr: v.mr, mw: v.mw, width: v.width};
        return e;
    endfunction

    task automatic check(input int id, input out_t e);
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL vec%0d: got valid=%0b pc=%h ao=%h a3=%0d exc=%0d bd=%0b rd=%0b wr=%0b (%h) want valid=%0b pc=%h ao=%h a3=%0d exc=%0d bd=%0b rd=%0b wr=%0b (%h)",
                     id, act.valid, act.pc, act.ao, act.a3, act.exc, act.bd, act.mr, act.mw, act,
                     e.valid, e.pc, e.ao, e.a3, e.exc, e.bd, e.mr, e.mw, e);
        end
    endtask

    task automatic drive(input int id, input in_t v, input out_t e);
        @(negedge clk);
        vin = v;
        exp_q.push_back(e);
        id_q.push_back(id);
    endtask

    initial begin : monitor
        out_t e;
        int   id;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                check(id, e);
            end
        end
    end

    initial begin : stimulus
        in_t  v;
        out_t e, last, rst_val;
        rst_val    = '0;
        rst_val.pc = 32'h0000_3000;
        vin   = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        drive(0, '0, rst_val);

        v = '0; v.en = 1; v.valid = 1; v.pc = 32'h3000; v.instr = 32'h0109_5020;
        v.ao = 32'h1234_5678; v.ovchk = 1; v.rt = 32'h0000_aaaa; v.a3 = 5'd10;
        drive(1, v, pass(v));

        v = '0; v.en = 1; v.valid = 1; v.pc = 32'h3004; v.instr = 32'h0232_8820;
        v.ao = 32'h8000_0000; v.ovf = 1; v.ovchk = 1; v.rt = 32'h11; v.a3 = 5'd8;
        e = pass(v); e.exc = 5'd12; e.a3 = 5'd0;
        drive(2, v, e);

        v = '0; v.en = 1; v.valid = 1; v.pc = 32'h3008; v.instr = 32'hac08_0000;
        v.ao = 32'h7fff_fffc; v.ovf = 1; v.ovchk = 1; v.rt = 32'h55; v.mw = 1;
        e = pass(v); e.exc = 5'd5; e.mw = 1'b0;
        drive(3, v, e);

        v.pc = 32'h300c; v.exc = 5'd10;
        e = pass(v); e.exc = 5'd10; e.mw = 1'b0;
        drive(4, v, e);

        v = '0; v.en = 1; v.valid = 1; v.pc = 32'h3010; v.ao = 32'h8000_0004;
        v.ovf = 1; v.ovchk = 1; v.mr = 1; v.a3 = 5'd9;
        e = pass(v); e.exc = 5'd4; e.mr = 1'b0; e.a3 = 5'd0;
        drive(5, v, e);

        v = '0; v.en = 1; v.valid = 1; v.pc = 32'h3014; v.ao = 32'hffff_fff0;
        v.ovf = 1; v.a3 = 5'd3;
        drive(6, v, pass(v));

        v = '0; v.en = 1; v.valid = 0; v.pc = 32'h3018; v.exc = 5'd10;
        v.ovf = 1; v.ovchk = 1; v.a3 = 5'd7; v.mr = 1; v.ao = 32'h44;
        e = pass(v);
        drive(7, v, e);

        v = '0; v.en = 1; v.valid = 1; v.pc = 32'h301c; v.ao = 32'h1000; v.mr = 1;
        v.a3 = 5'd4; v.rt = 32'h99; v.instr = 32'h8c04_1000;
        last = pass(v);
        drive(8, v, last);

        for (int i = 0; i < 3; i++) begin
            v.en = 0; v.pc = 32'h5000 + 32'(i * 4); v.ao = 32'h2000 + 32'(i);
            v.a3 = 5'(i + 11); v.ovf = 1; v.ovchk = 1;
            drive(9 + i, v, last);
        end

        v = '0; v.flush = 1; v.pc = 32'h3010; v.bd = 1; v.valid = 1; v.mr = 1;
        v.a3 = 5'd6; v.ao = 32'h1234;
        e = '0; e.pc = 32'h3010; e.bd = 1'b1;
        drive(12, v, e);

        v = '0; v.req = 1; v.flush = 1; v.en = 1; v.valid = 1; v.pc = 32'h3020;
        v.bd = 1; v.mw = 1; v.a3 = 5'd2;
        e = '0; e.pc = 32'h4180;
        drive(13, v, e);

        v = '0; v.en = 1; v.valid = 1; v.pc = 32'h3024; v.ao = 32'h2000; v.a3 = 5'd2;
        v.rt = 32'h77; v.bd = 1;
        drive(14, v, pass(v));

        // Asynchronous reset mid-cycle must clear outputs without waiting for an edge.
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check(100, rst_val);
        #1 reset = 1'b0;

        v = '0; v.valid = 1; v.pc = 32'h3028; v.a3 = 5'd1; v.ao = 32'hdead_beef;
        drive(15, v, rst_val);

        v = '0; v.en = 1; v.valid = 1; v.pc = 32'h302c; v.ao = 32'h1002; v.mr = 1;
        v.a3 = 5'd5;
        e = pass(v);
`ifdef EM_ALIGN_CHECK_EN
        e.exc = 5'd4; e.mr = 1'b0; e.a3 = 5'd0;
`endif
        drive(16, v, e);

        v.pc = 32'h3030; v.width = 2'b01;
        drive(17, v, pass(v));

        v = '0; v.en = 1; v.valid = 1; v.pc = 32'h3034; v.ao = 32'h1001; v.mw = 1;
        v.rt = 32'h1234_5678;
        e = pass(v);
`ifdef EM_ALIGN_CHECK_EN
        e.exc = 5'd5; e.mw = 1'b0;
`endif
        drive(18, v, e);

        v.pc = 32'h3038; v.ao = 32'h1003; v.width = 2'b10;
        drive(19, v, pass(v));

        v = '0; v.en = 1; v.valid = 1; v.pc = 32'h303c; v.ao = 32'h1001; v.mr = 1;
        v.width = 2'b01; v.a3 = 5'd12;
        e = pass(v);
`ifdef EM_ALIGN_CHECK_EN
        e.exc = 5'd4; e.mr = 1'b0; e.a3 = 5'd0;
`endif
        drive(20, v, e);

        v = '0; v.flush = 1; v.en = 1; v.valid = 1; v.pc = 32'h3040; v.a3 = 5'd3;
        v.ao = 32'h10;
        e = '0; e.pc = 32'h3040;
        drive(21, v, e);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
